// File: rtl/controle_partida_pkg.sv
// Shared constants for the game controller: FSM state encodings, shot-clock reload
// values and the helper that resolves simultaneous shot-clock reload requests.
package controle_partida_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_RUNNING    = 3'd1;
    localparam logic [2:0] ST_PAUSED     = 3'd2;
    localparam logic [2:0] ST_PERIOD_END = 3'd3;
    localparam logic [2:0] ST_GAME_END   = 3'd4;

    localparam logic [4:0] SHOT_RELOAD_24 = 5'd24;
    localparam logic [4:0] SHOT_RELOAD_14 = 5'd14;

    localparam logic [5:0] SEG_MAX = 6'd59;

    // A basket (or a forced restart) outranks an offensive rebound.
    function automatic logic [4:0] shot_reload(input logic full, input logic rebound);
        if (full)
            return SHOT_RELOAD_24;
        else if (rebound)
            return SHOT_RELOAD_14;
        else
            return SHOT_RELOAD_24;
    endfunction

endpackage

// File: rtl/relogio_jogo.sv
// Loadable mm:ss game-clock down-counter. It stops at 00:00 and exposes flags for
// 00:00 and 00:01 so the controller can detect the last second.
module relogio_jogo
    import controle_partida_pkg::*;
#(
    parameter int PERIOD_MIN = 10
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic       dec,
    output logic [3:0] minutos,
    output logic [5:0] segundos,
    output logic       zero,
    output logic       last
);

    localparam logic [3:0] MIN_RELOAD = 4'(PERIOD_MIN);

    assign zero = (minutos == 4'd0) && (segundos == 6'd0);
    assign last = (minutos == 4'd0) && (segundos == 6'd1);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            minutos  <= MIN_RELOAD;
            segundos <= 6'd0;
        end else if (load) begin
            minutos  <= MIN_RELOAD;
            segundos <= 6'd0;
        end else if (dec && !zero) begin
            if (segundos == 6'd0) begin
                minutos  <= minutos - 4'd1;
                segundos <= SEG_MAX;
            end else begin
                segundos <= segundos - 6'd1;
            end
        end
    end

endmodule

// File: rtl/controle_partida.sv
// Basketball game controller: period FSM, shot-clock reload control and the
// end-of-period buzzer. All outputs are registered.
module controle_partida
    import controle_partida_pkg::*;
#(
    parameter int PERIOD_MIN  = 10,
    parameter int NUM_PERIODS = 4,
    parameter int BUZZ_TICKS  = 3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick_1hz,
    input  logic       start_pause,
    input  logic       score_event,
    input  logic       rebound,
    input  logic       shot_zero,
    output logic [3:0] minutos,
    output logic [5:0] segundos,
    output logic [2:0] periodo,
    output logic       shot_reset,
    output logic       shot_sel14,
    output logic       shot_run,
    output logic       buzzer,
    output logic [2:0] estado
);

    localparam logic [2:0] LAST_PERIOD = 3'(NUM_PERIODS);
    localparam logic [2:0] BUZZ_LAST   = 3'(BUZZ_TICKS - 1);

    logic [2:0] state_nxt;
    logic [2:0] periodo_nxt;
    logic [2:0] buzz_cnt;
    logic [2:0] buzz_cnt_nxt;
    logic       buzzer_nxt;
    logic       clk_load;
    logic       clk_dec;
    logic       clock_zero;
    logic       clock_last;
    logic       shot_pulse;
    logic       force24;
    logic [4:0] shot_value;

    relogio_jogo #(
        .PERIOD_MIN(PERIOD_MIN)
    ) u_relogio (
        .clk      (clk),
        .clr      (clr),
        .load     (clk_load),
        .dec      (clk_dec),
        .minutos  (minutos),
        .segundos (segundos),
        .zero     (clock_zero),
        .last     (clock_last)
    );

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        state_nxt    = estado;
        periodo_nxt  = periodo;
        buzz_cnt_nxt = buzz_cnt;
        buzzer_nxt   = buzzer;
        clk_load     = 1'b0;
        clk_dec      = 1'b0;
        shot_pulse   = 1'b0;
        force24      = 1'b0;
        shot_value   = SHOT_RELOAD_24;

        case (estado)
            ST_IDLE: begin
                if (start_pause) begin
                    state_nxt  = ST_RUNNING;
                    shot_pulse = 1'b1;
                end
            end

            ST_RUNNING: begin
                clk_dec    = tick_1hz;
                shot_pulse = score_event | rebound;
                shot_value = shot_reload(score_event, rebound);
                // Expiry of the period takes precedence over a pause request.
                if (tick_1hz && (clock_last || clock_zero)) begin
                    state_nxt    = ST_PERIOD_END;
                    buzzer_nxt   = 1'b1;
                    buzz_cnt_nxt = 3'd0;
                end else if (start_pause || shot_zero) begin
                    state_nxt = ST_PAUSED;
                end
            end

            ST_PAUSED: begin
                if (start_pause) begin
                    state_nxt = ST_RUNNING;
                    force24   = shot_zero;
                end
                shot_pulse = score_event | rebound | force24;
                shot_value = shot_reload(score_event | force24, rebound);
            end

            ST_PERIOD_END: begin
                if (tick_1hz) begin
                    if (buzz_cnt == BUZZ_LAST) begin
                        buzzer_nxt   = 1'b0;
                        buzz_cnt_nxt = 3'd0;
                        if (periodo < LAST_PERIOD) begin
                            periodo_nxt = periodo + 3'd1;
                            clk_load    = 1'b1;
                            state_nxt   = ST_IDLE;
                        end else begin
                            state_nxt = ST_GAME_END;
                        end
                    end else begin
                        buzz_cnt_nxt = buzz_cnt + 3'd1;
                    end
                end
            end

            ST_GAME_END: begin
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            estado     <= ST_IDLE;
            periodo    <= 3'd1;
            buzz_cnt   <= 3'd0;
            buzzer     <= 1'b0;
            shot_reset <= 1'b0;
            shot_sel14 <= 1'b0;
            shot_run   <= 1'b0;
        end else begin
            estado     <= state_nxt;
            periodo    <= periodo_nxt;
            buzz_cnt   <= buzz_cnt_nxt;
            buzzer     <= buzzer_nxt;
            shot_reset <= shot_pulse;
            shot_sel14 <= shot_pulse && (shot_value == SHOT_RELOAD_14);
            shot_run   <= (state_nxt == ST_RUNNING);
        end
    end

endmodule

// File: tb/tb_controle_partida.sv
// Directed self-checking bench for controle_partida with a 1-minute, 2-period
// game and a 2-tick buzzer.
module tb_controle_partida;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_RUNNING    = 3'd1;
    localparam logic [2:0] S_PAUSED     = 3'd2;
    localparam logic [2:0] S_PERIOD_END = 3'd3;
    localparam logic [2:0] S_GAME_END   = 3'd4;

    logic       clk = 1'b0;
    logic       clr;
    logic       tick_1hz;
    logic       start_pause;
    logic       score_event;
    logic       rebound;
    logic       shot_zero;
    logic [3:0] minutos;
    logic [5:0] segundos;
    logic [2:0] periodo;
    logic       shot_reset;
    logic       shot_sel14;
    logic       shot_run;
    logic       buzzer;
    logic [2:0] estado;

    int passed = 0;
    int total  = 0;

    controle_partida #(
        .PERIOD_MIN  (1),
        .NUM_PERIODS (2),
        .BUZZ_TICKS  (2)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .tick_1hz    (tick_1hz),
        .start_pause (start_pause),
        .score_event (score_event),
        .rebound     (rebound),
        .shot_zero   (shot_zero),
        .minutos     (minutos),
        .segundos    (segundos),
        .periodo     (periodo),
        .shot_reset  (shot_reset),
        .shot_sel14  (shot_sel14),
        .shot_run    (shot_run),
        .buzzer      (buzzer),
        .estado      (estado)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Inputs change on the falling edge, are captured on the next rising edge,
    // and outputs are sampled on the following falling edge.
    task automatic cycle();
        @(negedge clk);
        tick_1hz    = 1'b0;
        start_pause = 1'b0;
        score_event = 1'b0;
        rebound     = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            cycle();
        end
    endtask

    task automatic press();
        start_pause = 1'b1;
        cycle();
    endtask

    initial begin
        clr = 1'b1; tick_1hz = 1'b0; start_pause = 1'b0;
        score_event = 1'b0; rebound = 1'b0; shot_zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_estado", estado, S_IDLE);
        check("rst_min", minutos, 1);
        check("rst_seg", segundos, 0);
        check("rst_periodo", periodo, 1);
        check("rst_outs", {shot_reset, shot_sel14, shot_run, buzzer}, 4'b0000);
        clr = 1'b0;
        cycle();

        score_event = 1'b1; cycle();
        check("idle_score_ignored", shot_reset, 0);

        press();
        check("start_estado", estado, S_RUNNING);
        check("start_shot", {shot_reset, shot_sel14, shot_run}, 3'b101);
        cycle();
        check("start_pulse_width", shot_reset, 0);

        ticks(5);
        check("run5_time", {minutos, segundos}, {4'd0, 6'd55});
        press();
        check("pause_estado", estado, S_PAUSED);
        check("pause_run", shot_run, 0);
        ticks(3);
        check("pause_hold", {minutos, segundos}, {4'd0, 6'd55});
        press();
        check("resume_estado", estado, S_RUNNING);
        check("resume_no_reload", shot_reset, 0);

        score_event = 1'b1; rebound = 1'b1; cycle();
        check("both_reload", {shot_reset, shot_sel14}, 2'b10);
        cycle();
        check("both_single_pulse", shot_reset, 0);
        rebound = 1'b1; cycle();
        check("rebound_reload", {shot_reset, shot_sel14}, 2'b11);

        shot_zero = 1'b1; cycle();
        check("viol_estado", estado, S_PAUSED);
        start_pause = 1'b1; cycle();
        shot_zero = 1'b0;
        check("viol_resume_estado", estado, S_RUNNING);
        check("viol_resume_shot", {shot_reset, shot_sel14, shot_run}, 3'b101);

        ticks(54);
        check("at_0001", {minutos, segundos}, {4'd0, 6'd1});
        tick_1hz = 1'b1; start_pause = 1'b1; cycle();
        check("p1_end_estado", estado, S_PERIOD_END);
        check("p1_end_time", {minutos, segundos}, {4'd0, 6'd0});
        check("p1_end_outs", {buzzer, shot_run}, 2'b10);
        ticks(1);
        check("p1_buzz_tick1", buzzer, 1);
        score_event = 1'b1; cycle();
        check("pend_score_ignored", shot_reset, 0);
        ticks(1);
        check("p1_buzz_off", buzzer, 0);
        check("p2_idle", estado, S_IDLE);
        check("p2_periodo", periodo, 2);
        check("p2_reload", {minutos, segundos}, {4'd1, 6'd0});

        press();
        ticks(59);
        check("p2_0001", {minutos, segundos}, {4'd0, 6'd1});
        ticks(1);
        check("p2_end_estado", estado, S_PERIOD_END);
        ticks(2);
        check("game_end_estado", estado, S_GAME_END);
        check("game_end_outs", {buzzer, shot_run, minutos, segundos}, 12'd0);
        press();
        score_event = 1'b1; rebound = 1'b1; cycle();
        check("game_end_absorb", {estado, shot_reset}, {S_GAME_END, 1'b0});

        #2 clr = 1'b1;
        #1 check("clr_game_end", {estado, periodo, minutos, segundos}, {S_IDLE, 3'd1, 4'd1, 6'd0});
        clr = 1'b0;
        cycle();

        press();
        ticks(60);
        check("p1b_buzzer_on", {estado, buzzer}, {S_PERIOD_END, 1'b1});
        #2 clr = 1'b1;
        #1 check("clr_buzz_async", {estado, buzzer}, {S_IDLE, 1'b0});
        score_event = 1'b1;
        cycle();
        clr = 1'b0;
        cycle();
        cycle();
        check("clr_no_pulse", {shot_reset, buzzer, shot_run}, 3'b000);
        check("clr_state", {estado, periodo, minutos, segundos}, {S_IDLE, 3'd1, 4'd1, 6'd0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/controle_partida.md
CONTROLE_PARTIDA -- requirements
Module: controle_partida

Interface
REQ-001 Parameter: PERIOD_MIN, 10, period length in minutes (1..15).
REQ-002 Parameter: NUM_PERIODS, 4, periods per game (1..7).
REQ-003 Parameter: BUZZ_TICKS, 3, buzzer duration in 1 Hz ticks at period end (1..7).
REQ-004 Port: clk  in  1  system clock; single clock domain, all state on rising edge.
REQ-005 Port: clr  in  1  reset, asynchronous, active-high.
REQ-006 Port: tick_1hz  in  1  one-clk-wide enable pulse, once per second.
REQ-007 Port: start_pause  in  1  one-clk pulse, debounced start/pause request.
REQ-008 Port: score_event  in  1  one-clk pulse, valid basket accepted by the scoreboard.
REQ-009 Port: rebound  in  1  one-clk pulse, offensive rebound / 14 s restart.
REQ-010 Port: shot_zero  in  1  level, shot clock at zero.
REQ-011 Port: minutos  out  4  game clock minutes, binary.
REQ-012 Port: segundos  out  6  game clock seconds, binary 0..59.
REQ-013 Port: periodo  out  3  current period, 1..NUM_PERIODS.
REQ-014 Port: shot_reset  out  1  one-clk pulse: reload shot clock.
REQ-015 Port: shot_sel14  out  1  reload value select, valid with shot_reset (1 = 14 s, 0 = 24 s).
REQ-016 Port: shot_run  out  1  shot clock count enable.
REQ-017 Port: buzzer  out  1  end-of-period horn.
REQ-018 Port: estado  out  3  FSM state encoding, for debug/LEDs.

Function
REQ-019 FSM states: IDLE, RUNNING, PAUSED, PERIOD_END, GAME_END. All outputs are registered and reflect inputs one clk later.
REQ-020 IDLE + start_pause -> RUNNING; shot_reset=1 with shot_sel14=0 in the same cycle.
REQ-021 RUNNING + tick_1hz: mm:ss decrements by one second. 00 seconds with minutes > 0 -> 59 seconds, minutes-1.
REQ-022 RUNNING + tick_1hz at 00:01 -> clock 00:00, state PERIOD_END, buzzer=1, shot_run=0.
REQ-023 RUNNING + start_pause -> PAUSED. PAUSED + start_pause -> RUNNING. Game clock holds in PAUSED.
REQ-024 RUNNING + shot_zero=1 -> PAUSED (violation stop).
REQ-025 PAUSED + start_pause while shot_zero=1 -> RUNNING plus shot_reset with 24 s.
REQ-026 score_event in RUNNING or PAUSED -> shot_reset=1, shot_sel14=0.
REQ-027 rebound in RUNNING or PAUSED -> shot_reset=1, shot_sel14=1.
REQ-028 score_event and rebound in the same cycle -> score wins (24 s).
REQ-029 Both score_event and rebound are ignored in IDLE, PERIOD_END and GAME_END.
REQ-030 shot_run=1 only in RUNNING; 0 in every other state.
REQ-031 tick_1hz reaching 00:00 and start_pause in the same cycle -> period end wins; start_pause is dropped.
REQ-032 PERIOD_END: buzzer stays high for BUZZ_TICKS tick_1hz pulses, counted from the tick that entered PERIOD_END (exclusive). Then buzzer=0, and:
  - periodo < NUM_PERIODS -> periodo+1, clock reload PERIOD_MIN:00, -> IDLE.
  - otherwise -> GAME_END, clock holds 00:00.
REQ-033 GAME_END is absorbing: all pulse inputs are ignored until clr.
REQ-034 Inputs other than clk/clr are assumed synchronous to clk; no internal synchronizers.

Reset
REQ-035 clr=1 asynchronously forces:
  - state IDLE
  - minutos=PERIOD_MIN, segundos=0, periodo=1
  - shot_reset=0, shot_sel14=0, shot_run=0, buzzer=0
  - buzzer counter 0
REQ-036 clr asserted mid-period or mid-buzzer aborts immediately. No pending pulse is emitted after release.

Structure
REQ-037 State encoding constants and the 24/14 reload values belong in the shared scoreboard package.
REQ-038 A single sub-module, relogio_jogo (loadable mm:ss down-counter with zero flag), is instantiated. The FSM, shot-clock control and buzzer counter stay in controle_partida.

Verification (PERIOD_MIN=1, NUM_PERIODS=2, BUZZ_TICKS=2)
REQ-039 clr, start_pause, 60 ticks -> 01:00 counts to 00:00; PERIOD_END; buzzer high for 2 ticks; then IDLE, periodo=2, clock 01:00.
REQ-040 Start, 5 ticks, start_pause, 3 ticks -> PAUSED at 00:55, clock still 00:55, shot_run=0.
REQ-041 RUNNING, score_event and rebound same cycle -> single shot_reset pulse with shot_sel14=0; rebound alone -> shot_sel14=1.
REQ-042 RUNNING, shot_zero=1 -> PAUSED next clk; start_pause -> RUNNING and shot_reset (24 s).
REQ-043 Finish period 2 -> GAME_END; start_pause, score_event ignored; clr -> IDLE, periodo=1, 01:00.
REQ-044 clr pulse while buzzer=1 -> buzzer=0 asynchronously, IDLE, no shot_reset afterwards.
